// File: rtl/spi_write_controller.sv
// SPI mode-0 write-frame master: {W=1, addr[6:0], data[7:0]} MSB first under one nCS.
// Optional macro SPI_CTRL_ADDR_CHECK_EN rejects requests with wr_addr > MAX_ADDR (err pulse).
module spi_write_controller #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned CS_GAP   = 2,
   parameter int unsigned MAX_ADDR = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       SCLK,
   output logic       COPI,
   output logic       nCS
);

   if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
      $error("CLK_DIV must be in 1..255");
   end
   if (CS_GAP < 1 || CS_GAP > 255) begin : g_bad_cs_gap
      $error("CS_GAP must be in 1..255");
   end
   if (MAX_ADDR > 127) begin : g_bad_max_addr
      $error("MAX_ADDR must fit in 7 bits");
   end

   localparam logic [7:0] C_HALF_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] C_GAP_LAST  = 8'(CS_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_HOLD,
      S_GAP
   } state_t;

   state_t      r_state;
   state_t      w_state_nx;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nx;
   logic [3:0]  r_bit;
   logic [3:0]  w_bit_nx;
   logic [15:0] r_sr;
   logic [15:0] w_sr_nx;
   logic        r_sclk;
   logic        r_ncs;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic        w_done_nx;
   logic        w_err_nx;
   logic        w_half_end;
   logic        w_reject;
   logic        w_in_frame_nx;

`ifdef SPI_CTRL_ADDR_CHECK_EN
   localparam logic [6:0] C_MAX_ADDR = 7'(MAX_ADDR);
   assign w_reject = (wr_addr > C_MAX_ADDR);
`else
   assign w_reject = 1'b0;
`endif

   assign w_half_end = (r_cnt == C_HALF_LAST);

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_bit_nx   = r_bit;
      w_sr_nx    = r_sr;
      w_done_nx  = 1'b0;
      w_err_nx   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_reject) begin
                  w_err_nx = 1'b1;
               end else begin
                  w_state_nx = S_SETUP;
                  w_cnt_nx   = '0;
                  w_bit_nx   = 4'd15;
                  w_sr_nx    = {1'b1, wr_addr, wr_data};
               end
            end
         end
         S_SETUP: begin
            if (w_half_end) begin
               w_state_nx = S_HIGH;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt + 8'd1;
            end
         end
         S_HIGH: begin
            if (w_half_end) begin
               w_state_nx = S_LOW;
               w_cnt_nx   = '0;
               // COPI moves on with the falling SCLK; bit 0 is held through HOLD
               if (r_bit != 4'd0) begin
                  w_sr_nx = {r_sr[14:0], 1'b0};
               end
            end else begin
               w_cnt_nx = r_cnt + 8'd1;
            end
         end
         S_LOW: begin
            if (w_half_end) begin
               w_cnt_nx = '0;
               if (r_bit == 4'd0) begin
                  w_state_nx = S_HOLD;
               end else begin
                  w_state_nx = S_HIGH;
                  w_bit_nx   = r_bit - 4'd1;
               end
            end else begin
               w_cnt_nx = r_cnt + 8'd1;
            end
         end
         S_HOLD: begin
            if (w_half_end) begin
               w_state_nx = S_GAP;
               w_cnt_nx   = '0;
               w_done_nx  = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + 8'd1;
            end
         end
         S_GAP: begin
            if (r_cnt == C_GAP_LAST) begin
               w_state_nx = S_IDLE;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt + 8'd1;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
         end
      endcase
   end

   assign w_in_frame_nx = (w_state_nx == S_SETUP) || (w_state_nx == S_HIGH) ||
                          (w_state_nx == S_LOW)   || (w_state_nx == S_HOLD);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_sr    <= '0;
         r_sclk  <= 1'b0;
         r_ncs   <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_bit   <= w_bit_nx;
         r_sr    <= w_sr_nx;
         r_sclk  <= (w_state_nx == S_HIGH);
         r_ncs   <= ~w_in_frame_nx;
         r_busy  <= (w_state_nx != S_IDLE);
         r_done  <= w_done_nx;
         r_err   <= w_err_nx;
      end
   end

   assign SCLK = r_sclk;
   assign COPI = r_sr[15];
   assign nCS  = r_ncs;
   assign busy = r_busy;
   assign done = r_done;
   assign err  = r_err;

endmodule
